parity_frame_checker: RTL
=========================

Name: parity_frame_checker

Overview:
- Receive end of the team's 4-input parity LUT path: deserialises a bit stream of frames (DATA_W data bits, MSB first, then one parity bit).
- Recomputes parity, flags mismatches and keeps a saturating error count.
- Sits between the simulated serial link and the result/LED logic in the FPGA sim designs.
- Parity convention: the parity bit is 1 when the data word holds an odd number of 1s, so a good frame has even total ones.

Parameters:
DATA_W, 4, data bits per frame (2..16)
CNT_W, 8, width of the saturating error counter

Ports:
clk  input  1  single system clock, rising edge
rst_n  input  1  synchronous active-low reset
bit_in  input  1  serial data/parity bit
bit_valid  input  1  bit_in is sampled on a clk edge when high
abort  input  1  synchronous frame abort; drops the partial frame
frame_data  output  DATA_W  last completed data word
frame_valid  output  1  one-cycle pulse when frame_data and parity_err are updated
parity_err  output  1  valid with frame_valid: 1 when the frame failed parity
sticky_err  output  1  set on any parity error, cleared only by reset or clr_err
clr_err  input  1  clears sticky_err and err_count
err_count  output  CNT_W  saturating count of failed frames
busy  output  1  high while a frame is partially received

Behaviour:
- Reset: on a clk edge with rst_n=0, all outputs go to 0, the FSM goes to IDLE, and the shift register and bit counter clear. Reset mid-frame discards the frame.
- FSM states and transitions:
  - IDLE: on bit_valid, load bit_in as the data MSB, set bit count to 1, go to DATA.
  - DATA: on each bit_valid, shift in the bit and increment the count. When the count reaches DATA_W, go to PARITY.
  - PARITY: on bit_valid, take bit_in as the received parity and go to REPORT.
  - REPORT: stays one cycle.
    - frame_valid=1 and frame_data is the assembled word.
    - parity_err = XOR of the data bits XOR the received parity.
    - Then return to IDLE.
- Cycles with bit_valid low hold state; there are no timeouts.
- Latency: frame_valid is asserted exactly 1 cycle after the clk edge that samples the parity bit.
- A bit_valid during REPORT is not lost. It is taken as the first data bit of the next frame, and the FSM goes to DATA with count 1, so back-to-back frames need no gap.
- busy = 1 in DATA and PARITY; 0 in IDLE and REPORT.
- abort:
  - In DATA or PARITY: return to IDLE, with no frame_valid and no counter change.
  - In REPORT: the report still completes.
  - abort has priority over bit_valid in the same cycle.
- frame_data and parity_err hold their values until the next REPORT.
- err_count:
  - Increments on REPORT with parity_err=1.
  - Saturates at 2^CNT_W-1 and never wraps.
  - If clr_err and an error report occur in the same cycle, the result is count=1 and sticky_err=1 (the new error wins over the clear).
  - clr_err alone sets both to 0 on the next edge.
- Parity calculation is XOR reduction of DATA_W+1 bits, purely combinational, with no added latency.

Decomposition:
- Package parity_pkg holds:
  - the state enum: IDLE, DATA, PARITY, REPORT;
  - the function odd_parity(word) returning the XOR reduction;
  - the constant ERR_SAT = {CNT_W{1'b1}}, derived locally from CNT_W.
- One sub-module, sat_counter (width CNT_W, inc, clr, same-cycle rule above), used for err_count.
- The FSM and shift register stay in the top module.

Test Plan:
1. Good frame: send data bits 1,0,1,1 then parity 1 (1011 has three ones, so parity=1) -> frame_valid pulse 1 cycle after the parity bit, frame_data=4'b1011, parity_err=0, err_count=0.
2. Bad frame: send 0,1,1,0 then parity 1 -> frame_data=4'b0110, parity_err=1, sticky_err=1, err_count=1.
3. Back-to-back frames with bit_valid held high for 10 cycles (frames 0000/0 then 1111/1) -> two frame_valid pulses, the second frame's first bit absorbed in REPORT, parity_err=0 then 1, err_count=1.
4. Gapped bits and abort:
   - Send 3 data bits with bit_valid low between them, then abort -> busy falls, no frame_valid, err_count unchanged.
   - Then a full good frame -> reports correctly.
5. Saturation with CNT_W=2: five bad frames -> err_count reads 1,2,3,3,3.
   - clr_err in the same cycle as a 6th bad REPORT -> err_count=1.
6. Reset mid-frame: rst_n=0 after 2 data bits -> next edge busy=0, all outputs 0.
   - Next full frame 1000/1 -> frame_data=4'b1000, parity_err=0.

Source files
------------

// File: rtl/parity_frame_checker_pkg.sv
// Shared types and helpers for the serial parity frame checker.
package parity_pkg;

  // Receive FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    REPORT = 2'd3
  } state_e;

  // Widest frame supported: 16 data bits plus one parity bit
  localparam int MAX_W     = 17;
  localparam int CNT_W_DEF = 8;
  localparam logic [CNT_W_DEF-1:0] ERR_SAT = {CNT_W_DEF{1'b1}};

  // XOR reduction; narrower words are zero-extended, which leaves parity unchanged
  function automatic logic odd_parity(input logic [MAX_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/parity_frame_checker_if.sv
// Serial-in / frame-report bundle between the link model and the checker.
interface parity_frame_checker_if #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
);
  logic              bit_in;
  logic              bit_valid;
  logic              abort;
  logic              clr_err;
  logic [DATA_W-1:0] frame_data;
  logic              frame_valid;
  logic              parity_err;
  logic              sticky_err;
  logic [CNT_W-1:0]  err_count;
  logic              busy;

  modport master (
    output bit_in, bit_valid, abort, clr_err,
    input  frame_data, frame_valid, parity_err, sticky_err, err_count, busy
  );

  modport slave (
    input  bit_in, bit_valid, abort, clr_err,
    output frame_data, frame_valid, parity_err, sticky_err, err_count, busy
  );
endinterface

// File: rtl/parity_frame_checker_sat_counter.sv
// Saturating up-counter with clear; a same-cycle increment beats the clear.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);
  localparam logic [CNT_W-1:0] ERR_SAT = {CNT_W{1'b1}};

  logic [CNT_W-1:0] count_q, count_d;

  // Next count: increment (restarting from zero if cleared), clear, or hold
  always_comb begin
    count_d = count_q;
    if (inc) begin
      if (clr)                  count_d = CNT_W'(1);
      else if (count_q != ERR_SAT) count_d = count_q + CNT_W'(1);
    end else if (clr) begin
      count_d = '0;
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/parity_frame_checker.sv
// Deserialises MSB-first frames with a trailing parity bit and reports errors.
module parity_frame_checker
  import parity_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  parity_frame_checker_if.slave  bus
);
  localparam int CW = $clog2(DATA_W + 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] frame_data_q, frame_data_d;
  logic              frame_valid_q, frame_valid_d;
  logic              parity_err_q, parity_err_d;
  logic              sticky_q, sticky_d;
  logic              err_evt;

  // Frame FSM; report registers load on the parity-bit edge so they are
  // visible throughout the single REPORT cycle
  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    cnt_d         = cnt_q;
    frame_data_d  = frame_data_q;
    parity_err_d  = parity_err_q;
    frame_valid_d = 1'b0;
    err_evt       = 1'b0;
    case (state_q)
      IDLE, REPORT: begin
        if (state_q == REPORT) state_d = IDLE;
        // a bit arriving during REPORT starts the next frame with no gap
        if (!bus.abort && bus.bit_valid) begin
          shift_d = DATA_W'(bus.bit_in);
          cnt_d   = CW'(1);
          state_d = DATA;
        end
      end
      DATA: begin
        if (bus.abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (bus.bit_valid) begin
          shift_d = {shift_q[DATA_W-2:0], bus.bit_in};
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(DATA_W - 1)) state_d = PARITY;
        end
      end
      PARITY: begin
        if (bus.abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (bus.bit_valid) begin
          frame_valid_d = 1'b1;
          frame_data_d  = shift_q;
          parity_err_d  = odd_parity(MAX_W'({shift_q, bus.bit_in}));
          err_evt       = parity_err_d;
          cnt_d         = '0;
          state_d       = REPORT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sticky flag: a new error wins over a same-cycle clear
  always_comb begin
    sticky_d = sticky_q;
    if (err_evt)          sticky_d = 1'b1;
    else if (bus.clr_err) sticky_d = 1'b0;
  end

  // State, datapath and report registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      cnt_q         <= '0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      parity_err_q  <= 1'b0;
      sticky_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      cnt_q         <= cnt_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      parity_err_q  <= parity_err_d;
      sticky_q      <= sticky_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (err_evt),
    .clr   (bus.clr_err),
    .count (bus.err_count)
  );

  assign bus.frame_data  = frame_data_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.parity_err  = parity_err_q;
  assign bus.sticky_err  = sticky_q;
  assign bus.busy        = (state_q == DATA) || (state_q == PARITY);
endmodule
